nonce_scan: RTL

Reads the per-nonce hash words written by the hashing core, one word per nonce at consecutive addresses starting at `input_addr`. Scans them over the shared word-addressed memory port and reports the winning nonce: the minimum unsigned hash word, or, with early exit compiled in, the first word below `target`. It sits downstream of the hashing core on the same memory bus and runs once per `start`.

---
 rtl/nonce_scan.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/nonce_scan.sv
// nonce_scan: finds the minimum hash word, or with NONCE_SCAN_EARLY_EXIT_EN the first word below target, over a word-addressed memory.
// Latency NUM_NONCES+2 cycles from start (less on an early exit); one read per cycle, no backpressure.
module nonce_scan #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] input_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [31:0] best_nonce,
    output logic [31:0] best_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data
);

    localparam int IW = $clog2(NUM_NONCES + 1);
    localparam logic [IW-1:0] N_L    = IW'(NUM_NONCES);
    localparam logic [IW-1:0] LAST_L = IW'(NUM_NONCES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] issue_idx;
    logic [IW-1:0] cmp_idx;
    logic [IW-1:0] best_idx_q;
    logic [15:0]   base_q;
    logic [31:0]   target_q;
    logic [31:0]   best_q;
    logic          a_vld;
    logic          d_vld;
    logic          hit_q;
    logic          accept;
    logic          issue;
    logic          do_cmp;
    logic          early_hit;
    logic          finish;

    assign mem_clk = clk;
    assign mem_we  = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // a_vld: an address was registered last edge; d_vld: its data is on the bus now.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        do_cmp    = 1'b0;
        finish    = 1'b0;
        early_hit = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                issue  = (issue_idx < N_L);
                do_cmp = d_vld;
                if (issue_idx >= LAST_L) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (hit_q || (!a_vld && !d_vld)) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    do_cmp = d_vld;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef NONCE_SCAN_EARLY_EXIT_EN
        early_hit = do_cmp && (mem_read_data < target_q);
`else
        early_hit = 1'b0;
`endif
        if (early_hit) begin
            state_nxt = DRAIN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done       <= 1'b0;
            found      <= 1'b0;
            best_nonce <= 32'h0;
            best_hash  <= 32'h0;
            mem_addr   <= 16'h0;
            base_q     <= 16'h0;
            target_q   <= 32'h0;
            best_q     <= 32'h0;
            best_idx_q <= '0;
            issue_idx  <= '0;
            cmp_idx    <= '0;
            a_vld      <= 1'b0;
            d_vld      <= 1'b0;
            hit_q      <= 1'b0;
        end else if (accept) begin
            // Index 0 is issued on the accepting edge so data for index i is compared at T+2+i.
            base_q     <= input_addr;
            target_q   <= target;
            mem_addr   <= input_addr;
            issue_idx  <= IW'(1);
            cmp_idx    <= '0;
            best_q     <= 32'hFFFF_FFFF;
            best_idx_q <= '0;
            done       <= 1'b0;
            a_vld      <= 1'b1;
            d_vld      <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            a_vld <= issue;
            d_vld <= a_vld;
            if (issue) begin
                mem_addr  <= base_q + 16'(issue_idx);
                issue_idx <= issue_idx + 1'b1;
            end
            if (do_cmp) begin
                cmp_idx <= cmp_idx + 1'b1;
                if (early_hit || (mem_read_data < best_q)) begin
                    best_q     <= mem_read_data;
                    best_idx_q <= cmp_idx;
                end
                if (early_hit) begin
                    hit_q <= 1'b1;
                end
            end
            if (finish) begin
                done       <= 1'b1;
                best_hash  <= best_q;
                best_nonce <= 32'(best_idx_q);
                found      <= (best_q < target_q);
            end
        end
    end

endmodule
